// File: rtl/x0_handshake.sv
// Control sequencer for the X0 transfer channel: four return-to-zero ack
// handshakes, then hold Dt until senack, pulse Cclear, and return to idle.
module x0_handshake #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic ack,
  input  logic X0,
  input  logic senack,
  output logic A,
  output logic B,
  output logic C,
  output logic Cclear,
  output logic Dt,
  output logic bit0,
  output logic bit1
);

  // One-hot codes so every output is a single state flop: no logic between the
  // register and the pin, and mutual exclusion holds by construction.
  typedef enum logic [3:0] {
    IDLE    = 4'b0000,
    WAIT_HI = 4'b0001,
    WAIT_LO = 4'b0010,
    DONE    = 4'b0100,
    CLEAR   = 4'b1000
  } state_t;

  state_t                 state;
  logic [1:0]             idx;
  logic [SYNC_STAGES-1:0] ack_q;
  logic [SYNC_STAGES-1:0] x0_q;
  logic [SYNC_STAGES-1:0] senack_q;
  logic                   ack_s;
  logic                   x0_s;
  logic                   senack_s;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_q    <= '0;
      x0_q     <= '0;
      senack_q <= '0;
    end else begin
      ack_q    <= {ack_q[SYNC_STAGES-2:0], ack};
      x0_q     <= {x0_q[SYNC_STAGES-2:0], X0};
      senack_q <= {senack_q[SYNC_STAGES-2:0], senack};
    end
  end

  assign ack_s    = ack_q[SYNC_STAGES-1];
  assign x0_s     = x0_q[SYNC_STAGES-1];
  assign senack_s = senack_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx   <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          // A lingering senack from the previous transfer blocks a restart.
          if (x0_s && !senack_s) begin
            state <= WAIT_HI;
            idx   <= 2'd0;
          end
        end
        WAIT_HI: begin
          if (ack_s) state <= WAIT_LO;
        end
        WAIT_LO: begin
          if (!ack_s) begin
            if (idx == 2'd3) begin
              state <= DONE;
            end else begin
              idx   <= idx + 2'd1;
              state <= WAIT_HI;
            end
          end
        end
        DONE: begin
          if (senack_s) state <= CLEAR;
        end
        CLEAR: begin
          state <= IDLE;
          idx   <= 2'd0;
        end
        default: begin
          state <= IDLE;
          idx   <= 2'd0;
        end
      endcase
    end
  end

  assign A      = state[0];
  assign B      = state[1];
  assign C      = state[2];
  assign Dt     = state[2];
  assign Cclear = state[3];
  assign bit0   = idx[0];
  assign bit1   = idx[1];

endmodule

// File: tb/tb_x0_handshake.sv
// Scoreboard bench for x0_handshake: expected output vectors are queued as
// stimulus is driven and compared at negedges after the synchroniser latency.
module tb_x0_handshake;

  logic clk = 1'b0;
  logic reset;
  logic ack;
  logic X0;
  logic senack;
  logic A, B, C, Cclear, Dt, bit0, bit1;

  int checks = 0;
  int errors = 0;

  typedef enum int {S_IDLE, S_A, S_B, S_C, S_CLR} exp_state_t;

  logic [6:0] sb[$];
  logic [6:0] exp_v;

  x0_handshake #(.SYNC_STAGES(2)) dut (
    .clk    (clk),
    .reset  (reset),
    .ack    (ack),
    .X0     (X0),
    .senack (senack),
    .A      (A),
    .B      (B),
    .C      (C),
    .Cclear (Cclear),
    .Dt     (Dt),
    .bit0   (bit0),
    .bit1   (bit1)
  );

  always #5 clk = ~clk;

  // Vector order: {A, B, C, Cclear, Dt, bit1, bit0}
  function automatic logic [6:0] ev(input exp_state_t s, input int i);
    logic [1:0] b;
    b = i[1:0];
    case (s)
      S_A:     return {5'b10000, b};
      S_B:     return {5'b01000, b};
      S_C:     return {5'b00101, b};
      S_CLR:   return {5'b00010, b};
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [6:0] obs();
    return {A, B, C, Cclear, Dt, bit1, bit0};
  endfunction

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One ack rise/fall for bit i; each level held 4 cycles.
  task automatic run_bits(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      ack = 1'b1;
      sb.push_back(ev(S_A, i));
      ticks(2);
      exp_v = sb.pop_front(); checks++;
      if (obs() !== exp_v) begin errors++; $display("FAIL bit%0d_rise_early: got %b want %b", i, obs(), exp_v); end
      sb.push_back(ev(S_B, i));
      ticks(1);
      exp_v = sb.pop_front(); checks++;
      if (obs() !== exp_v) begin errors++; $display("FAIL bit%0d_rise: got %b want %b", i, obs(), exp_v); end
      ticks(1);
      ack = 1'b0;
      sb.push_back(ev(S_B, i));
      ticks(2);
      exp_v = sb.pop_front(); checks++;
      if (obs() !== exp_v) begin errors++; $display("FAIL bit%0d_fall_early: got %b want %b", i, obs(), exp_v); end
      sb.push_back((i < 3) ? ev(S_A, i + 1) : ev(S_C, 3));
      ticks(1);
      exp_v = sb.pop_front(); checks++;
      if (obs() !== exp_v) begin errors++; $display("FAIL bit%0d_fall: got %b want %b", i, obs(), exp_v); end
      ticks(1);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; X0 = 1'b1; ack = 1'b0; senack = 1'b0;
    for (int k = 0; k < 6; k++) begin
      ack = ~ack;
      sb.push_back(ev(S_IDLE, 0));
      ticks(1);
      exp_v = sb.pop_front(); checks++;
      if (obs() !== exp_v) begin errors++; $display("FAIL reset_hold%0d: got %b want %b", k, obs(), exp_v); end
    end
    ack = 1'b0;
    ticks(1);
    reset = 1'b0;
    sb.push_back(ev(S_IDLE, 0));
    ticks(2);
    exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin errors++; $display("FAIL reset_release_early: got %b want %b", obs(), exp_v); end
    sb.push_back(ev(S_A, 0));
    ticks(1);
    exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin errors++; $display("FAIL reset_release_start: got %b want %b", obs(), exp_v); end
  endtask

  task automatic test_full_transaction();
    run_bits(0, 3);
    senack = 1'b1;
    sb.push_back(ev(S_C, 3));
    ticks(2);
    exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin errors++; $display("FAIL full_senack_early: got %b want %b", obs(), exp_v); end
    sb.push_back(ev(S_CLR, 3));
    ticks(1);
    exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin errors++; $display("FAIL full_cclear: got %b want %b", obs(), exp_v); end
    sb.push_back(ev(S_IDLE, 0));
    ticks(1);
    exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin errors++; $display("FAIL full_cclear_one_cycle: got %b want %b", obs(), exp_v); end
  endtask

  task automatic test_restart_blocking();
    for (int k = 0; k < 4; k++) begin
      sb.push_back(ev(S_IDLE, 0));
      ticks(1);
      exp_v = sb.pop_front(); checks++;
      if (obs() !== exp_v) begin errors++; $display("FAIL restart_blocked%0d: got %b want %b", k, obs(), exp_v); end
    end
    senack = 1'b0;
    sb.push_back(ev(S_IDLE, 0));
    ticks(2);
    exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin errors++; $display("FAIL restart_early: got %b want %b", obs(), exp_v); end
    sb.push_back(ev(S_A, 0));
    ticks(1);
    exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin errors++; $display("FAIL restart_start: got %b want %b", obs(), exp_v); end
  endtask

  task automatic test_early_x0_drop();
    run_bits(0, 0);
    X0 = 1'b0;
    run_bits(1, 3);
    senack = 1'b1;
    sb.push_back(ev(S_CLR, 3));
    ticks(3);
    exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin errors++; $display("FAIL x0drop_cclear: got %b want %b", obs(), exp_v); end
    ticks(1);
    senack = 1'b0;
    sb.push_back(ev(S_IDLE, 0));
    ticks(4);
    exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin errors++; $display("FAIL x0drop_idle: got %b want %b", obs(), exp_v); end
  endtask

  task automatic test_spurious();
    X0 = 1'b1;
    sb.push_back(ev(S_A, 0));
    ticks(3);
    exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin errors++; $display("FAIL spur_start: got %b want %b", obs(), exp_v); end
    senack = 1'b1;
    for (int k = 0; k < 5; k++) begin
      sb.push_back(ev(S_A, 0));
      ticks(1);
      exp_v = sb.pop_front(); checks++;
      if (obs() !== exp_v) begin errors++; $display("FAIL spur_senack%0d: got %b want %b", k, obs(), exp_v); end
    end
    senack = 1'b0;
    ticks(4);
    run_bits(0, 3);
    ack = 1'b1;
    for (int k = 0; k < 5; k++) begin
      sb.push_back(ev(S_C, 3));
      ticks(1);
      exp_v = sb.pop_front(); checks++;
      if (obs() !== exp_v) begin errors++; $display("FAIL spur_ack_hi%0d: got %b want %b", k, obs(), exp_v); end
    end
    ack = 1'b0;
    sb.push_back(ev(S_C, 3));
    ticks(5);
    exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin errors++; $display("FAIL spur_ack_lo: got %b want %b", obs(), exp_v); end
    X0 = 1'b0;
    senack = 1'b1;
    sb.push_back(ev(S_CLR, 3));
    ticks(3);
    exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin errors++; $display("FAIL spur_cclear: got %b want %b", obs(), exp_v); end
    ticks(1);
    senack = 1'b0;
    ticks(3);
  endtask

  task automatic test_async_reset();
    X0 = 1'b1;
    sb.push_back(ev(S_A, 0));
    ticks(3);
    exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin errors++; $display("FAIL areset_start: got %b want %b", obs(), exp_v); end
    run_bits(0, 1);
    ack = 1'b1;
    sb.push_back(ev(S_B, 2));
    ticks(3);
    exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin errors++; $display("FAIL areset_waitlo: got %b want %b", obs(), exp_v); end
    #2 reset = 1'b1;
    sb.push_back(ev(S_IDLE, 0));
    #1;
    exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin errors++; $display("FAIL areset_immediate: got %b want %b", obs(), exp_v); end
    for (int k = 0; k < 4; k++) begin
      sb.push_back(ev(S_IDLE, 0));
      ticks(1);
      exp_v = sb.pop_front(); checks++;
      if (obs() !== exp_v) begin errors++; $display("FAIL areset_hold%0d: got %b want %b", k, obs(), exp_v); end
    end
    ack = 1'b0;
    X0 = 1'b0;
    reset = 1'b0;
    sb.push_back(ev(S_IDLE, 0));
    ticks(4);
    exp_v = sb.pop_front(); checks++;
    if (obs() !== exp_v) begin errors++; $display("FAIL areset_after: got %b want %b", obs(), exp_v); end
  endtask

  initial begin
    test_reset();
    test_full_transaction();
    test_restart_blocking();
    test_early_x0_drop();
    test_spurious();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/x0_handshake.md
Name: x0_handshake

Overview:
- Control sequencer for the X0 transfer channel.
- Once the X0 request is raised, it steps through four return-to-zero ack handshakes and tracks the bit index on bit1:bit0. It then holds data-transfer (Dt) until the downstream send-acknowledge (senack), pulses Cclear, and returns to idle.
- Sits between the X0 request source and the ack/senack responders. Responder inputs are asynchronous, so the block synchronises them internally.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on each of ack, X0 and senack (minimum 2).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- ack  input  1  per-bit acknowledge from responder, level-based return-to-zero; asynchronous.
- X0  input  1  transfer request, level; asynchronous.
- senack  input  1  send-complete acknowledge, level; asynchronous.
- A  output  1  high in WAIT_HI (waiting for ack to rise).
- B  output  1  high in WAIT_LO (waiting for ack to fall).
- C  output  1  high in DONE (all four bits handshaken).
- Cclear  output  1  one-cycle pulse in CLEAR state.
- Dt  output  1  data-transfer valid, high in DONE.
- bit0  output  1  LSB of current bit index.
- bit1  output  1  MSB of current bit index.

Behaviour:
- Clock and reset: one clock (clk). reset is asynchronous and active-high. While reset=1: state=IDLE, index=0, all sync flops=0, all outputs 0.
- Input synchronisation: ack, X0 and senack each pass through SYNC_STAGES flops, giving ack_s, X0_s and senack_s. The FSM only uses these synchronised versions.
- Outputs are Moore decodes of the registered state and index; there is no combinational path from input to output.
- Latency: a pin change is reflected in the outputs at the (SYNC_STAGES+1)th rising edge after the change. This is 3 edges with the default.
- States, one-hot or encoded (implementer's choice): IDLE, WAIT_HI, WAIT_LO, DONE, CLEAR.
- IDLE:
  - Outputs all 0.
  - Go to WAIT_HI when X0_s=1 and senack_s=0, with index=0.
  - X0 is level-sensitive. If X0 is held high after a transaction, a new transaction starts as soon as senack_s is 0.
- WAIT_HI:
  - A=1.
  - When ack_s=1, go to WAIT_LO.
- WAIT_LO:
  - B=1.
  - When ack_s=0: if index<3, increment index and go to WAIT_HI; if index==3, go to DONE with index held at 3.
- DONE:
  - C=1, Dt=1, index holds 3.
  - When senack_s=1, go to CLEAR.
- CLEAR:
  - Cclear=1 for exactly one cycle. Index is cleared to 0 on the exit edge.
  - Always go to IDLE next.
- Index behaviour:
  - bit1:bit0 is the index of the bit currently being handshaken (0..3). It never wraps inside a transaction.
- Ignored inputs:
  - X0 deasserting after IDLE has no effect. The transaction runs to completion and there is no abort.
  - ack activity in IDLE, DONE and CLEAR is ignored.
  - senack outside DONE is ignored, except that senack_s=1 blocks the IDLE->WAIT_HI start.
- Simultaneous changes: when ack and senack change together, each state examines only its own input, so there is no priority conflict.
- Reset mid-operation: returns immediately (asynchronously) to IDLE with index=0 and all outputs 0. No Cclear pulse is generated.
- Mutual exclusion: exactly one of A, B, C, Cclear is high outside IDLE. Dt==C at all times.

Test Plan:
- Reset: assert reset with X0=1 and ack toggling -> all outputs 0 and bit1:bit0=00 throughout. Release reset with X0=1 -> A=1 three edges later.
- Full transaction:
  - X0=1.
  - Four ack 0->1->0 pulses, each level held at least 4 cycles -> A/B alternate and bit1:bit0 steps 00,01,10,11.
  - After the 4th ack falls -> C=1, Dt=1, index=11.
  - senack=1 -> Cclear high for exactly 1 cycle, then IDLE with index 00.
- Restart blocking: after CLEAR with X0=1 and senack still 1 -> stays IDLE. Drop senack to 0 -> WAIT_HI (A=1) three edges later.
- Early X0 drop: X0 falls during bit index 01 -> sequence continues. Remaining acks still drive the index to 11 and DONE.
- Spurious inputs: senack pulse during WAIT_HI and ack pulse during DONE -> no state or index change.
- Async reset mid-transfer: reset asserted in WAIT_LO at index 10 -> outputs 0 immediately (before the next edge), no Cclear, index 00.
